// File: rtl/timer_delay_scheduler.sv
// timer_delay_scheduler: round-robin sequencer that shares one interval-timer
// peripheral between NUM_REQ requesters. It programs a one-shot delay, waits for
// the timer irq, clears the timeout status and pulses done to the granted requester.
// Ports: req/req_ticks in, done/busy/grant_id out (requester side);
//        tmr_address/tmr_chipselect/tmr_write_n/tmr_writedata out, tmr_irq in (timer side).
// Latency: grant to done is T+7 cycles (1 cycle when T<2); every output is registered.
module timer_delay_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [32*NUM_REQ-1:0] req_ticks,
   output logic [NUM_REQ-1:0]    done,
   output logic                  busy,
   output logic [IDW-1:0]        grant_id,
   output logic [2:0]            tmr_address,
   output logic                  tmr_chipselect,
   output logic                  tmr_write_n,
   output logic [15:0]           tmr_writedata,
   input  logic                  tmr_irq
);

   localparam logic [2:0]  A_STATUS   = 3'd0;
   localparam logic [2:0]  A_CONTROL  = 3'd1;
   localparam logic [2:0]  A_PERIOD_L = 3'd2;
   localparam logic [2:0]  A_PERIOD_H = 3'd3;
   localparam logic [15:0] CTRL_STOP  = 16'h0008;
   localparam logic [15:0] CTRL_START = 16'h0005;   // START + ITO, one-shot

   typedef enum logic [3:0] {
      IDLE, SHORT, WR_STOP, WR_PL, WR_PH, WR_CLR, WR_START,
      WAIT_IRQ, CLR_DONE, CAN_STOP, CAN_CLR
   } state_t;

   state_t state, next_state;

   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     arb_idx;
   logic               arb_found;
   logic [31:0]        arb_ticks;
   logic [31:0]        period;
   int                 arb_cand;

   logic [NUM_REQ-1:0] done_nxt;
   logic               busy_nxt;
   logic               cs_nxt;
   logic               wn_nxt;
   logic [2:0]         addr_nxt;
   logic [15:0]        data_nxt;

   // Circular search for the first set req bit at or after rr_ptr.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_cand  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_cand = int'(rr_ptr) + k;
         if (arb_cand >= NUM_REQ)
            arb_cand = arb_cand - NUM_REQ;
         if (!arb_found && req[IDW'(arb_cand)]) begin
            arb_found = 1'b1;
            arb_idx   = IDW'(arb_cand);
         end
      end
      arb_ticks = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (arb_idx == IDW'(i))
            arb_ticks = req_ticks[32*i +: 32];
   end

   // State register plus the registered bus/status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         grant_id       <= '0;
         period         <= '0;
         done           <= '0;
         busy           <= 1'b0;
         tmr_chipselect <= 1'b0;
         tmr_write_n    <= 1'b1;
         tmr_address    <= A_STATUS;
         tmr_writedata  <= '0;
      end else begin
         state          <= next_state;
         done           <= done_nxt;
         busy           <= busy_nxt;
         tmr_chipselect <= cs_nxt;
         tmr_write_n    <= wn_nxt;
         tmr_address    <= addr_nxt;
         tmr_writedata  <= data_nxt;
         if (state == IDLE && arb_found) begin
            grant_id <= arb_idx;
            rr_ptr   <= (arb_idx == IDW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
            period   <= arb_ticks - 32'd1;
         end
      end
   end

   // Next-state logic. req is only looked at in IDLE and WAIT_IRQ; irq beats a
   // withdrawal seen in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (arb_found) next_state = (arb_ticks < 32'd2) ? SHORT : WR_STOP;
         SHORT:    next_state = IDLE;
         WR_STOP:  next_state = WR_PL;
         WR_PL:    next_state = WR_PH;
         WR_PH:    next_state = WR_CLR;
         WR_CLR:   next_state = WR_START;
         WR_START: next_state = WAIT_IRQ;
         WAIT_IRQ: begin
            if (tmr_irq)
               next_state = CLR_DONE;
            else if (!req[grant_id])
               next_state = CAN_STOP;
         end
         CLR_DONE: next_state = IDLE;
         CAN_STOP: next_state = CAN_CLR;
         CAN_CLR:  next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Output values for the state being entered, so the registered outputs line
   // up with the state register. period is already latched when WR_PL is entered.
   always_comb begin
      cs_nxt   = 1'b0;
      wn_nxt   = 1'b1;
      addr_nxt = A_STATUS;
      data_nxt = '0;
      done_nxt = '0;
      case (next_state)
         WR_STOP, CAN_STOP: begin
            cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_CONTROL; data_nxt = CTRL_STOP;
         end
         WR_PL: begin
            cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_PERIOD_L; data_nxt = period[15:0];
         end
         WR_PH: begin
            cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_PERIOD_H; data_nxt = period[31:16];
         end
         WR_CLR, CAN_CLR: begin
            cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_STATUS;
         end
         WR_START: begin
            cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_CONTROL; data_nxt = CTRL_START;
         end
         CLR_DONE: begin
            cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_STATUS;
            done_nxt[grant_id] = 1'b1;
         end
         SHORT:   done_nxt[arb_idx] = 1'b1;
         default: ;
      endcase
      busy_nxt = (next_state != IDLE);
   end

endmodule

// File: tb/tb_timer_delay_scheduler.sv
module tb_timer_delay_scheduler;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [32*N-1:0] req_ticks;
   logic [N-1:0]    done;
   logic            busy;
   logic [1:0]      grant_id;
   logic [2:0]      tmr_address;
   logic            tmr_chipselect;
   logic            tmr_write_n;
   logic [15:0]     tmr_writedata;
   logic            tmr_irq;

   always #5 clk = ~clk;

   timer_delay_scheduler #(.NUM_REQ(N), .IDW(2)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_ticks(req_ticks),
      .done(done), .busy(busy), .grant_id(grant_id),
      .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
      .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
   );

   // Interval timer peripheral model: period registers, one-shot countdown,
   // timeout flag cleared by a status write, irq = TO & ITO.
   logic [15:0] t_pl, t_ph;
   logic [31:0] t_cnt;
   logic        t_run, t_to, t_ito;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_pl <= '0; t_ph <= '0; t_cnt <= '0; t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
      end else if (tmr_chipselect && !tmr_write_n) begin
         case (tmr_address)
            3'd0: t_to <= 1'b0;
            3'd1: begin
               t_ito <= tmr_writedata[0];
               if (tmr_writedata[3]) t_run <= 1'b0;
               else if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= {t_ph, t_pl}; end
            end
            3'd2: t_pl <= tmr_writedata;
            3'd3: t_ph <= tmr_writedata;
            default: ;
         endcase
      end else if (t_run) begin
         if (t_cnt == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
         else t_cnt <= t_cnt - 1;
      end
   end
   assign tmr_irq = t_to & t_ito;

   // Scoreboard
   typedef struct { int cyc; logic [2:0] a; logic [15:0] d; } wr_t;
   typedef struct { int cyc; logic [N-1:0] v; } dn_t;
   wr_t exp_wr[$];
   dn_t exp_done[$];
   bit  exp_busy[int];
   int  exp_gid[int];
   wr_t we;
   dn_t de;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int m_rr = 0;
   int irq_cnt = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the expected event whenever the DUT presents a write or done.
   always @(negedge clk) begin
      if (mon_en) begin
         check("strobe_pair", tmr_write_n, !tmr_chipselect);
         if (tmr_chipselect) begin
            if (exp_wr.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write (cycle %0d)",
                        tmr_address, tmr_writedata, cyc);
            end else begin
               we = exp_wr.pop_front();
               check("wr_cycle", cyc, we.cyc);
               check("wr_addr", tmr_address, we.a);
               check("wr_data", tmr_writedata, we.d);
            end
         end
         if (done != '0) begin
            if (exp_done.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got 0x%0h, required none (cycle %0d)", done, cyc);
            end else begin
               de = exp_done.pop_front();
               check("done_cycle", cyc, de.cyc);
               check("done_vec", done, de.v);
            end
         end
         check("busy", busy, exp_busy.exists(cyc));
         if (exp_gid.exists(cyc)) check("grant_id", grant_id, exp_gid[cyc]);
         if (tmr_irq) irq_cnt++;
      end
   end

   task automatic wait_cycle(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push_wr(input int c, input logic [2:0] a, input logic [15:0] d);
      wr_t e;
      e.cyc = c; e.a = a; e.d = d;
      exp_wr.push_back(e);
   endtask

   task automatic push_done(input int c, input int w);
      dn_t e;
      e.cyc = c; e.v = '0; e.v[w] = 1'b1;
      exp_done.push_back(e);
   endtask

   task automatic mark_busy(input int from, input int to, input int w);
      for (int c = from; c <= to; c++) begin exp_busy[c] = 1'b1; exp_gid[c] = w; end
   endtask

   task automatic drained();
      check("exp_wr_drained", exp_wr.size(), 0);
      check("exp_done_drained", exp_done.size(), 0);
   endtask

   // Reference model of one grant, called at the IDLE cycle g: round-robin pick
   // from the current req vector, then the programming writes when T>=2.
   task automatic grant_step(output int w, output int g, output logic [31:0] t);
      logic [31:0] p;
      bit found;
      g = cyc; w = 0; found = 1'b0;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_rr + k) % N;
         if (!found && req[c]) begin found = 1'b1; w = c; end
      end
      t = req_ticks[32*w +: 32];
      m_rr = (w + 1) % N;
      if (t >= 2) begin
         p = t - 1;
         push_wr(g+1, 3'd1, 16'h0008);
         push_wr(g+2, 3'd2, p[15:0]);
         push_wr(g+3, 3'd3, p[31:16]);
         push_wr(g+4, 3'd0, 16'h0000);
         push_wr(g+5, 3'd1, 16'h0005);
      end
   endtask

   // drop: 0 keep req, 1 drop winner's bit, 2 drop all bits (in the done cycle)
   task automatic finish_normal(input int w, input int g, input logic [31:0] t,
                                input int drop, input bit mutate);
      int dc;
      if (t < 2) begin
         dc = g + 1;
         push_done(dc, w);
         mark_busy(g+1, g+1, w);
      end else begin
         dc = g + int'(t) + 7;
         push_wr(dc, 3'd0, 16'h0000);
         push_done(dc, w);
         mark_busy(g+1, dc, w);
         if (mutate) begin
            wait_cycle(g+3);
            req_ticks[32*w +: 32] = $urandom;
         end
      end
      wait_cycle(dc);
      if (drop == 1) req[w] = 1'b0;
      if (drop == 2) req = '0;
      wait_cycle(dc+1);
      drained();
   endtask

   // Withdrawal at cycle d; noticed in WAIT_IRQ (entered at g+6) at the earliest.
   task automatic finish_cancel(input int w, input int g, input int d);
      int s;
      s = ((d > g+6) ? d : g+6) + 1;
      push_wr(s,   3'd1, 16'h0008);
      push_wr(s+1, 3'd0, 16'h0000);
      mark_busy(g+1, s+1, w);
      wait_cycle(d);
      req[w] = 1'b0;
      wait_cycle(s+2);
      drained();
   endtask

   function automatic logic [31:0] rand_ticks();
      if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 1));
      return 32'($urandom_range(2, 40));
   endfunction

   task automatic reset_checks(input string tag);
      check({tag, "_done"}, done, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_grant_id"}, grant_id, 0);
      check({tag, "_chipselect"}, tmr_chipselect, 0);
      check({tag, "_write_n"}, tmr_write_n, 1);
      check({tag, "_address"}, tmr_address, 0);
      check({tag, "_writedata"}, tmr_writedata, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int w, g;
      logic [31:0] t;
      reset_n = 1'b0; req = '0; req_ticks = '0;
      repeat (3) @(negedge clk);
      reset_checks("reset");
      reset_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Round-robin with all requests held: order 0,1,2,3,0, done 17 after each grant
      req = 4'hF;
      for (int i = 0; i < N; i++) req_ticks[32*i +: 32] = 32'd10;
      for (int k = 0; k < 5; k++) begin
         grant_step(w, g, t);
         finish_normal(w, g, t, (k == 4) ? 2 : 0, 1'b0);
      end

      // Single request, T=100
      req = 4'b0001; req_ticks[0 +: 32] = 32'd100;
      grant_step(w, g, t);
      finish_normal(w, g, t, 1, 1'b0);

      // Short requests T=0 and T=1
      req = 4'b0100; req_ticks[64 +: 32] = 32'd0;
      grant_step(w, g, t);
      finish_normal(w, g, t, 1, 1'b0);
      req = 4'b1000; req_ticks[96 +: 32] = 32'd1;
      grant_step(w, g, t);
      finish_normal(w, g, t, 1, 1'b0);

      // 32-bit delay crossing the 16-bit boundary
      req = 4'b0100; req_ticks[64 +: 32] = 32'h0001_0000;
      grant_step(w, g, t);
      finish_normal(w, g, t, 1, 1'b0);

      // Cancel 20 cycles into WAIT_IRQ; irq must never rise
      req = 4'b0010; req_ticks[32 +: 32] = 32'd1000;
      grant_step(w, g, t);
      irq_cnt = 0;
      finish_cancel(w, g, g + 26);
      check("cancel_no_irq", irq_cnt, 0);

      // Next request served normally
      req = 4'b0010; req_ticks[32 +: 32] = 32'd25;
      grant_step(w, g, t);
      finish_normal(w, g, t, 1, 1'b0);

      // Maximum delay: period words 0xFFFE / 0xFFFF, then withdrawn
      req = 4'b0001; req_ticks[0 +: 32] = 32'hFFFF_FFFF;
      grant_step(w, g, t);
      finish_cancel(w, g, g + 12);

      // Randomized traffic with overlapping requests and withdrawals
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N; i++)
            if (!req[i] && $urandom_range(0, 1) == 1) begin
               req[i] = 1'b1;
               req_ticks[32*i +: 32] = rand_ticks();
            end
         if (req == '0) begin
            int j;
            j = $urandom_range(0, N-1);
            req[j] = 1'b1;
            req_ticks[32*j +: 32] = rand_ticks();
         end
         grant_step(w, g, t);
         if (t >= 2 && $urandom_range(0, 4) == 0)
            finish_cancel(w, g, g + 1 + $urandom_range(0, int'(t) + 3));
         else
            finish_normal(w, g, t, 1, 1'b1);
      end
      req = '0;
      @(negedge clk);
      @(negedge clk);

      // Reset pulsed during WAIT_IRQ
      req = 4'b1000; req_ticks[96 +: 32] = 32'd200;
      grant_step(w, g, t);
      mark_busy(g+1, g+31, w);
      wait_cycle(g+30);
      #2;
      reset_n = 1'b0;
      req = '0;
      exp_wr.delete(); exp_done.delete(); exp_busy.delete(); exp_gid.delete();
      m_rr = 0;
      #1;
      reset_checks("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      req = 4'b0010; req_ticks[32 +: 32] = 32'd30;
      grant_step(w, g, t);
      finish_normal(w, g, t, 1, 1'b0);

      repeat (3) @(negedge clk);
      drained();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_delay_scheduler.md
# timer_delay_scheduler

Sequencer and round-robin arbiter that shares the single interval-timer peripheral between NUM_REQ hardware requesters, such as the actuator pulse generators. It grants one requester at a time and drives the timer's 16-bit register port to program a one-shot delay. It waits for the timer irq, clears the timeout status, then pulses done to the granted requester. It sits between the requester logic and the timer slave, replacing the CPU as master of that timer.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- IDW, default 2: width of grant_id, equal to clog2(NUM_REQ).
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request, one bit per requester; held until done or withdrawn.
- req_ticks  in  32*NUM_REQ  delay in clk cycles; requester i uses bits [32i+31:32i]; sampled at grant.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  IDW  index of the current or last granted requester.
- tmr_address  out  3  timer register select: 0 status, 1 control, 2 period_l, 3 period_h.
- tmr_chipselect  out  1  write-cycle select; the timer has no waitrequest.
- tmr_write_n  out  1  active-low write strobe.
- tmr_writedata  out  16  register write data.
- tmr_irq  in  1  timer interrupt, level; high while the timeout flag is set and ITO is 1.

## Operation
- Reset values: done=0, busy=0, grant_id=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, rr_ptr=0, state=IDLE.
- Every bus output is registered. A bus write cycle has tmr_chipselect=1 and tmr_write_n=0 for exactly one cycle. Outside write cycles, tmr_chipselect=0 and tmr_write_n=1.
- Control word bits are: 0 ITO, 1 CONT, 2 START, 3 STOP.
- Arbitration happens in IDLE:
  - The first set req bit at or after rr_ptr wins, searching circularly.
  - The winner's index is latched into grant_id, and its req_ticks is latched as T.
  - rr_ptr is set to grant_id+1 modulo NUM_REQ.
- Short request: if T<2, the FSM goes to SHORT. SHORT pulses done for one cycle, issues no bus writes and returns to IDLE.
- Otherwise P=T-1 (32-bit) and the FSM runs these states in order, one cycle each:
  - WR_STOP: address 1, data 0x0008.
  - WR_PL: address 2, data P[15:0].
  - WR_PH: address 3, data P[31:16].
  - WR_CLR: address 0, data 0. This clears any stale timeout flag and also serves as the reload settle cycle.
  - WR_START: address 1, data 0x0005 (START+ITO, one-shot).
  - WAIT_IRQ: entered after WR_START.
- WAIT_IRQ:
  - If tmr_irq=1, go to CLR_DONE.
  - Else, if req[grant_id]=0 (requester withdrew), go to CAN_STOP.
  - Else stay in WAIT_IRQ.
  - If tmr_irq=1 and req[grant_id] falls in the same cycle, irq wins.
- CLR_DONE: address 0, data 0, and done[grant_id]=1 in the same cycle. Then IDLE.
- CAN_STOP: address 1, data 0x0008. Then CAN_CLR.
- CAN_CLR: address 0, data 0. Then IDLE. No done pulse is given on a cancel.
- Withdrawal checks:
  - req bits are ignored in all states except IDLE and WAIT_IRQ.
  - A withdrawal during the programming states is detected once WAIT_IRQ is reached.
- A requester that keeps req high after done is re-arbitrated normally in the next IDLE. Round-robin then serves the others first.
- req_ticks changes after the grant are ignored.
- The full 32-bit range is supported; T=0xFFFFFFFF gives P=0xFFFFFFFE.

## Timing
- Cycle 0 is the IDLE cycle in which a req is first sampled.
- Normal request, T>=2:
  - Bus writes occur in cycles 1 through 5.
  - done is high in cycle T+7 only.
  - The FSM is back in IDLE at cycle T+8.
  - busy is high in cycles 1..T+7.
- Short request, T<2: done is high in cycle 1 only; the FSM is back in IDLE at cycle 2.
- Minimum spacing between two grants is T+8 cycles.
- Asserting reset mid-operation aborts immediately; all outputs return to their reset values. The timer is reset by the same reset_n, so no cleanup writes are needed.

## Test plan
- Single request: req=0001, ticks[0]=100.
  - Required response: writes (1,0x0008), (2,0x0063), (3,0x0000), (0,0), (1,0x0005) in cycles 1-5.
  - done[0] high in cycle 107 only.
- Round-robin: req=1111 held, each ticks=10.
  - Required response: grant order 0,1,2,3,0.
  - Each done occurs 17 cycles after its own grant cycle.
- 32-bit value: ticks[2]=0x0001_0000, req=0100.
  - Required response: period_l write 0xFFFF, period_h write 0x0000, done at cycle 65543.
- Short requests: ticks=0 and ticks=1.
  - Required response: done in cycle 1, no tmr_chipselect activity, busy high in cycle 1 only.
- Cancel: req[1] dropped 20 cycles into WAIT_IRQ, ticks=1000.
  - Required response: STOP write (1,0x0008), then status clear (0,0), no done.
  - Timer irq never rises, and the next request is served normally.
- Reset mid-operation: reset_n pulsed low during WAIT_IRQ.
  - Required response: all outputs at reset values, and a request 2 cycles later completes at T+7.
